case_8_mul_pipe_acc: RTL and testbench
======================================

# case_8_mul_pipe_acc

Pipelined, parameterised multiply-accumulate unit for the HLS datapath. It generalises the single-cycle combinational signed multiplier to:
- a configurable pipeline depth with a clock enable and valid tracking;
- per-operand signedness;
- an optional running accumulator with saturating or wrapping output.

The scheduler instantiates it wherever a multiply feeds a reduction loop, so the reduction does not need a separate adder and register.

## Interface
Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, latency in cycles from accepted input to output; legal range 1..8.
- din0_WIDTH, 8, width of operand A.
- din1_WIDTH, 7, width of operand B.
- dout_WIDTH, 16, width of the result and accumulator register.
- DIN0_SIGNED, 1, 1 = din0 is two's complement, 0 = unsigned.
- DIN1_SIGNED, 1, 1 = din1 is two's complement, 0 = unsigned.
- SATURATE, 1, 1 = clamp the result to the dout range, 0 = wrap by truncation.

Ports:
- ap_clk, in, 1, the single clock; all state updates on the rising edge.
- ap_rst, in, 1, reset: synchronous, active-high.
- ce, in, 1, clock enable; 0 freezes every register, including valids and ovf.
- in_vld, in, 1, operand valid; the input is accepted when ce=1 and in_vld=1.
- din0, in, din0_WIDTH, operand A.
- din1, in, din1_WIDTH, operand B.
- acc_en, in, 1, add this product to the accumulator instead of replacing it.
- acc_clr, in, 1, with acc_en=1: add to 0 instead of to the current accumulator value; also clears ovf.
- dout, out, dout_WIDTH, accumulator / result register.
- out_vld, out, 1, dout was updated by the result that completed this cycle.
- ovf, out, 1, sticky flag: a result did not fit in dout_WIDTH.

## Operation
- **Product.** Each operand is extended by 1 bit (sign- or zero-extended per its DIN*_SIGNED flag) and the two are multiplied.
  - Product P is PW = din0_WIDTH+din1_WIDTH bits, exact.
  - P is signed if either operand is signed, otherwise unsigned.
  - The dout interpretation follows the same signedness.
- **Pipeline.** NUM_STAGE register stages.
  - Stage 1 captures the operands, acc_en, acc_clr and the valid bit.
  - The multiply may be split across the intermediate stages.
  - The last stage performs the accumulate/resize and writes dout.
- **Last stage**, when ce=1 and its valid bit is 1:
  - Compute S = (acc_en ? (acc_clr ? 0 : dout) : 0) + P, at max(dout_WIDTH,PW)+1 bits with no loss.
  - If S fits dout_WIDTH: dout <= S.
  - If S does not fit and SATURATE=1: dout <= max or min of the dout range; ovf <= 1.
  - If S does not fit and SATURATE=0: dout <= S truncated; ovf <= 1.
  - out_vld <= 1.
- **acc_clr.** When an accepted acc_clr reaches the last stage, ovf is cleared first and then possibly set again by the same result.
- **Bubbles.** ce=1 with in_vld=0 inserts a bubble. When a bubble reaches the last stage: out_vld <= 0, and dout and ovf hold.
- **Stall.** When ce=0, out_vld holds its previous value; the consumer qualifies out_vld with ce.
- **Ordering.** Results emerge strictly in acceptance order; there is no back-pressure and no drop.

## Timing
- **Reset.** While ap_rst=1 at an edge, all pipeline valids, out_vld, dout and ovf go to 0; data registers go to 0. ap_rst overrides ce.
- **Reset mid-operation.** All in-flight items are discarded; no out_vld is produced for them.
- **Latency.** An input accepted at edge k appears on dout with out_vld=1 after edge k+NUM_STAGE−1, counting only edges with ce=1. With NUM_STAGE=1, the result is visible right after the accepting edge.
- **Throughput.** One input per ce cycle. Back-to-back accumulate chains are correct at full rate: the last stage reads the dout it wrote on the previous edge.
- **Post-reset.** The first input after reset with acc_en=1, acc_clr=0 accumulates onto 0.

## Test plan
- **Single product.** Defaults; din0=0x80 (−128), din1=0x40 (−64), acc_en=0, in_vld for 1 cycle → out_vld=1 exactly 3 cycles later, dout=0x2000 (8192), ovf=0.
- **Streaming.** 4 consecutive inputs (1×1, 2×3, −5×7, 127×−64) → out_vld high for 4 consecutive cycles with dout=1, 6, −35, −8128, in order.
- **Positive saturation.** 127×63 five times, first with acc_en=1 and acc_clr=1, the rest with acc_en=1 → dout 8001, 16002, 24003, 32004, 32767; ovf rises with the 5th result. Repeat with SATURATE=0 → 5th dout = 0x9C45 (wrapped), ovf=1.
- **Negative saturation and clear.**
  - −128×63 accumulated 5 times → −8064 … −32256, then −32768; ovf=1.
  - Next input with acc_clr=1, acc_en=1 → dout=−8064, ovf=0.
- **ce stall.** Drop ce for 2 cycles while 2 items are in flight → outputs delayed by exactly 2 cycles, values unchanged, dout and ovf stable during the stall.
- **Reset mid-flight and unsigned mode.** ap_rst for 1 cycle with 2 items in flight → no out_vld afterwards; dout=0, ovf=0. Then, with DIN0_SIGNED=0, DIN1_SIGNED=0: 255×127 → dout=32385.

Source files
------------

// File: rtl/case_8_mul_pipe_acc.sv
// Pipelined multiply-accumulate: NUM_STAGE register stages from operand capture to dout, with
// per-operand signedness, clock enable, valid tracking and a saturating or wrapping accumulator.
module case_8_mul_pipe_acc #(
  parameter int unsigned ID          = 1,
  parameter int unsigned NUM_STAGE   = 3,
  parameter int unsigned din0_WIDTH  = 8,
  parameter int unsigned din1_WIDTH  = 7,
  parameter int unsigned dout_WIDTH  = 16,
  parameter bit          DIN0_SIGNED = 1'b1,
  parameter bit          DIN1_SIGNED = 1'b1,
  parameter bit          SATURATE    = 1'b1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  in_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  acc_clr,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_vld,
  output logic                  ovf
);

  localparam int unsigned PW      = din0_WIDTH + din1_WIDTH;
  localparam int unsigned DW      = dout_WIDTH;
  // Two guard bits so both signed and unsigned sums are held without loss.
  localparam int unsigned SW      = ((DW > PW) ? DW : PW) + 2;
  localparam bit          PSIGNED = DIN0_SIGNED | DIN1_SIGNED;

  // Exact product: each operand gets one extension bit so the multiply is always signed.
  function automatic logic [PW-1:0] mul(input logic [din0_WIDTH-1:0] a,
                                        input logic [din1_WIDTH-1:0] b);
    logic signed [din0_WIDTH:0] ax;
    logic signed [din1_WIDTH:0] bx;
    logic signed [PW-1:0]       ae;
    logic signed [PW-1:0]       be;
    logic signed [PW-1:0]       full;
    ax   = {DIN0_SIGNED & a[din0_WIDTH-1], a};
    bx   = {DIN1_SIGNED & b[din1_WIDTH-1], b};
    ae   = PW'(ax);
    be   = PW'(bx);
    full = ae * be;
    return full;
  endfunction

  logic [PW-1:0] last_p;
  logic          last_vld;
  logic          last_en;
  logic          last_clr;

  if (NUM_STAGE == 1) begin : g_comb
    assign last_p   = mul(din0, din1);
    assign last_vld = in_vld;
    assign last_en  = acc_en;
    assign last_clr = acc_clr;
  end else begin : g_pipe
    logic [din0_WIDTH-1:0] a_q;
    logic [din1_WIDTH-1:0] b_q;
    logic                  s1_vld_q;
    logic                  s1_en_q;
    logic                  s1_clr_q;
    logic [PW-1:0]         s1_p;

    always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
        a_q      <= '0;
        b_q      <= '0;
        s1_vld_q <= 1'b0;
        s1_en_q  <= 1'b0;
        s1_clr_q <= 1'b0;
      end else if (ce) begin
        a_q      <= din0;
        b_q      <= din1;
        s1_vld_q <= in_vld;
        s1_en_q  <= acc_en;
        s1_clr_q <= acc_clr;
      end
    end

    assign s1_p = mul(a_q, b_q);

    if (NUM_STAGE == 2) begin : g_short
      assign last_p   = s1_p;
      assign last_vld = s1_vld_q;
      assign last_en  = s1_en_q;
      assign last_clr = s1_clr_q;
    end else begin : g_long
      localparam int unsigned ND = NUM_STAGE - 2;

      logic [PW-1:0] p_q   [ND];
      logic          vld_q [ND];
      logic          en_q  [ND];
      logic          clr_q [ND];

      always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
          for (int i = 0; i < int'(ND); i++) begin
            p_q[i]   <= '0;
            vld_q[i] <= 1'b0;
            en_q[i]  <= 1'b0;
            clr_q[i] <= 1'b0;
          end
        end else if (ce) begin
          p_q[0]   <= s1_p;
          vld_q[0] <= s1_vld_q;
          en_q[0]  <= s1_en_q;
          clr_q[0] <= s1_clr_q;
          for (int i = 1; i < int'(ND); i++) begin
            p_q[i]   <= p_q[i-1];
            vld_q[i] <= vld_q[i-1];
            en_q[i]  <= en_q[i-1];
            clr_q[i] <= clr_q[i-1];
          end
        end
      end

      assign last_p   = p_q[ND-1];
      assign last_vld = vld_q[ND-1];
      assign last_en  = en_q[ND-1];
      assign last_clr = clr_q[ND-1];
    end
  end

  logic [DW-1:0] dout_q, dout_d;
  logic          ovf_q, ovf_d;
  logic          out_vld_q;
  logic [SW-1:0] p_ext, acc_ext, base, sum;
  logic [DW-1:0] sat_val;
  logic          fits;

  always_comb begin
    p_ext   = {{(SW-PW){PSIGNED & last_p[PW-1]}}, last_p};
    acc_ext = {{(SW-DW){PSIGNED & dout_q[DW-1]}}, dout_q};
    base    = (last_en && !last_clr) ? acc_ext : '0;
    sum     = base + p_ext;
    // Signed: all bits from the dout sign bit up must agree. Unsigned: nothing above dout.
    fits    = PSIGNED ? ((&sum[SW-1:DW-1]) | ~(|sum[SW-1:DW-1])) : ~(|sum[SW-1:DW]);
    sat_val = '1;
    if (PSIGNED) begin
      sat_val = sum[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
    dout_d  = (fits || !SATURATE) ? sum[DW-1:0] : sat_val;
    ovf_d   = ((last_en && last_clr) ? 1'b0 : ovf_q) | ~fits;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dout_q    <= '0;
      ovf_q     <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (ce) begin
      out_vld_q <= last_vld;
      if (last_vld) begin
        dout_q <= dout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign dout    = dout_q;
  assign ovf     = ovf_q;
  assign out_vld = out_vld_q;

endmodule

// File: tb/tb_case_8_mul_pipe_acc.sv
// Directed bench: saturating, wrapping, unsigned and single-stage instances share one stimulus.
module tb_case_8_mul_pipe_acc;

  logic       ap_clk = 1'b0;
  logic       ap_rst;
  logic       ce;
  logic       in_vld;
  logic [7:0] din0;
  logic [6:0] din1;
  logic       acc_en;
  logic       acc_clr;

  logic [15:0] dout_a, dout_w, dout_u, dout_1;
  logic        vld_a, vld_w, vld_u, vld_1;
  logic        ovf_a, ovf_w, ovf_u, ovf_1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  case_8_mul_pipe_acc dut_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .dout(dout_a), .out_vld(vld_a), .ovf(ovf_a)
  );

  case_8_mul_pipe_acc #(.SATURATE(1'b0)) dut_w (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .dout(dout_w), .out_vld(vld_w), .ovf(ovf_w)
  );

  case_8_mul_pipe_acc #(.DIN0_SIGNED(1'b0), .DIN1_SIGNED(1'b0)) dut_u (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .dout(dout_u), .out_vld(vld_u), .ovf(ovf_u)
  );

  case_8_mul_pipe_acc #(.NUM_STAGE(1)) dut_1 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_vld(in_vld), .din0(din0), .din1(din1),
    .acc_en(acc_en), .acc_clr(acc_clr), .dout(dout_1), .out_vld(vld_1), .ovf(ovf_1)
  );

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [6:0] b,
                       input logic e, input logic c);
    in_vld  = v;
    din0    = a;
    din1    = b;
    acc_en  = e;
    acc_clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 7'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    ce     = 1'b1;
    idle();
    tick();
    tick();
    n_checks++;
    if (vld_a !== 1'b0 || dout_a !== 16'd0 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got vld=%b dout=%h ovf=%b want 0/0000/0", vld_a, dout_a, ovf_a);
    end
    n_checks++;
    if (vld_1 !== 1'b0 || dout_1 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state_s1: got vld=%b dout=%h want 0/0000", vld_1, dout_1);
    end
    ap_rst = 1'b0;
    // First accumulate after reset starts from 0.
    drive(1'b1, 8'd5, 7'd5, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (vld_1 !== 1'b1 || dout_1 !== 16'd25) begin
      n_fail++;
      $display("FAIL post_reset_acc_s1: got vld=%b dout=%0d want 1/25", vld_1, dout_1);
    end
    idle();
    tick();
    tick();
    n_checks++;
    if (vld_a !== 1'b1 || dout_a !== 16'd25 || ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_acc: got vld=%b dout=%0d ovf=%b want 1/25/0", vld_a, dout_a, ovf_a);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 8'h80, 7'h40, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (vld_1 !== 1'b1 || dout_1 !== 16'h2000) begin
      n_fail++;
      $display("FAIL single_s1: got vld=%b dout=%h want 1/2000", vld_1, dout_1);
    end
    idle();
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (i < 3 && vld_a !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early: cycle %0d got vld=%b want 0", i, vld_a);
      end
      if (i == 3 && (vld_a !== 1'b1 || dout_a !== 16'h2000 || ovf_a !== 1'b0)) begin
        n_fail++;
        $display("FAIL single_result: got vld=%b dout=%h ovf=%b want 1/2000/0", vld_a, dout_a,
                 ovf_a);
      end
      if (i < 3) tick();
    end
    tick();
    n_checks++;
    if (vld_a !== 1'b0 || dout_a !== 16'h2000) begin
      n_fail++;
      $display("FAIL bubble_hold: got vld=%b dout=%h want 0/2000", vld_a, dout_a);
    end
  endtask

  task automatic test_streaming();
    logic [7:0]  a [4];
    logic [6:0]  b [4];
    logic [15:0] exp_d [4];
    a     = '{8'd1, 8'd2, 8'hFB, 8'd127};
    b     = '{7'd1, 7'd3, 7'd7, 7'h40};
    exp_d = '{16'd1, 16'd6, 16'hFFDD, 16'hE040};
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, a[i], b[i], 1'b0, 1'b0);
      else idle();
      tick();
      n_checks++;
      if (i >= 2 && i < 6) begin
        if (vld_a !== 1'b1 || dout_a !== exp_d[i-2]) begin
          n_fail++;
          $display("FAIL stream_%0d: got vld=%b dout=%h want 1/%h", i - 2, vld_a, dout_a,
                   exp_d[i-2]);
        end
      end else if (vld_a !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_gap_%0d: got vld=%b want 0", i, vld_a);
      end
    end
  endtask

  task automatic test_pos_sat();
    logic [15:0] exp_a [5];
    logic [15:0] exp_w [5];
    logic        exp_o [5];
    exp_a = '{16'd8001, 16'd16002, 16'd24003, 16'd32004, 16'd32767};
    exp_w = '{16'd8001, 16'd16002, 16'd24003, 16'd32004, 16'h9C45};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      if (i < 5) drive(1'b1, 8'd127, 7'd63, 1'b1, i == 0);
      else idle();
      tick();
      if (i >= 2 && i < 7) begin
        n_checks++;
        if (vld_a !== 1'b1 || dout_a !== exp_a[i-2] || ovf_a !== exp_o[i-2]) begin
          n_fail++;
          $display("FAIL pos_sat_%0d: got vld=%b dout=%0d ovf=%b want 1/%0d/%b", i - 2, vld_a,
                   dout_a, ovf_a, exp_a[i-2], exp_o[i-2]);
        end
        n_checks++;
        if (dout_w !== exp_w[i-2] || ovf_w !== exp_o[i-2]) begin
          n_fail++;
          $display("FAIL pos_wrap_%0d: got dout=%h ovf=%b want %h/%b", i - 2, dout_w, ovf_w,
                   exp_w[i-2], exp_o[i-2]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 8'd10, 7'd10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'd20, 7'd3, 1'b0, 1'b0);
    tick();
    idle();
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    n_checks++;
    if (dout_a !== 16'd0 || ovf_a !== 1'b0 || dout_w !== 16'd0 || ovf_w !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: got dout=%h ovf=%b wrap dout=%h ovf=%b want all 0",
               dout_a, ovf_a, dout_w, ovf_w);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (vld_a !== 1'b0 || dout_a !== 16'd0) begin
        n_fail++;
        $display("FAIL midflight_drop_%0d: got vld=%b dout=%h want 0/0000", i, vld_a, dout_a);
      end
      tick();
    end
  endtask

  task automatic test_neg_sat_clear();
    logic [15:0] exp_a [6];
    logic [15:0] exp_w [6];
    logic        exp_o [6];
    exp_a = '{16'hE080, 16'hC100, 16'hA180, 16'h8200, 16'h8000, 16'hE080};
    exp_w = '{16'hE080, 16'hC100, 16'hA180, 16'h8200, 16'h6280, 16'hE080};
    exp_o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      if (i < 6) drive(1'b1, 8'h80, 7'h3F, 1'b1, (i == 0) || (i == 5));
      else idle();
      tick();
      if (i >= 2 && i < 8) begin
        n_checks++;
        if (vld_a !== 1'b1 || dout_a !== exp_a[i-2] || ovf_a !== exp_o[i-2]) begin
          n_fail++;
          $display("FAIL neg_sat_%0d: got vld=%b dout=%h ovf=%b want 1/%h/%b", i - 2, vld_a,
                   dout_a, ovf_a, exp_a[i-2], exp_o[i-2]);
        end
        n_checks++;
        if (dout_w !== exp_w[i-2] || ovf_w !== exp_o[i-2]) begin
          n_fail++;
          $display("FAIL neg_wrap_%0d: got dout=%h ovf=%b want %h/%b", i - 2, dout_w, ovf_w,
                   exp_w[i-2], exp_o[i-2]);
        end
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 8'd3, 7'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'hFE, 7'd5, 1'b0, 1'b0);
    tick();
    idle();
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (vld_a !== 1'b0 || dout_a !== 16'hE080 || ovf_a !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold_%0d: got vld=%b dout=%h ovf=%b want 0/e080/0", i, vld_a,
                 dout_a, ovf_a);
      end
    end
    ce = 1'b1;
    tick();
    n_checks++;
    if (vld_a !== 1'b1 || dout_a !== 16'd12) begin
      n_fail++;
      $display("FAIL stall_first: got vld=%b dout=%h want 1/000c", vld_a, dout_a);
    end
    tick();
    n_checks++;
    if (vld_a !== 1'b1 || dout_a !== 16'hFFF6) begin
      n_fail++;
      $display("FAIL stall_second: got vld=%b dout=%h want 1/fff6", vld_a, dout_a);
    end
    tick();
    n_checks++;
    if (vld_a !== 1'b0 || dout_a !== 16'hFFF6) begin
      n_fail++;
      $display("FAIL stall_drain: got vld=%b dout=%h want 0/fff6", vld_a, dout_a);
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] exp_u [3];
    logic        exp_o [3];
    logic [15:0] exp_s [3];
    exp_u = '{16'd32385, 16'd64770, 16'd65535};
    exp_o = '{1'b0, 1'b0, 1'b1};
    exp_s = '{16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1'b1, 8'hFF, 7'h7F, 1'b1, i == 0);
      else idle();
      tick();
      if (i >= 2 && i < 5) begin
        n_checks++;
        if (vld_u !== 1'b1 || dout_u !== exp_u[i-2] || ovf_u !== exp_o[i-2]) begin
          n_fail++;
          $display("FAIL unsigned_%0d: got vld=%b dout=%0d ovf=%b want 1/%0d/%b", i - 2, vld_u,
                   dout_u, ovf_u, exp_u[i-2], exp_o[i-2]);
        end
        n_checks++;
        if (dout_a !== exp_s[i-2] || ovf_a !== 1'b0) begin
          n_fail++;
          $display("FAIL signed_minus1_%0d: got dout=%0d ovf=%b want %0d/0", i - 2, dout_a,
                   ovf_a, exp_s[i-2]);
        end
      end
    end
  endtask

  initial begin
    ap_rst = 1'b1;
    ce     = 1'b1;
    idle();
    test_reset();
    test_single();
    test_streaming();
    test_pos_sat();
    test_reset_midflight();
    test_neg_sat_clear();
    test_stall();
    test_unsigned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
